// File: rtl/xge_pkt_tx_gen_pkg.sv
// Shared types, widths and the frame byte-pattern helper for the
// xge_mac transmit packet generator.
package xge_pkt_gen_pkg;

    localparam int DATA_W = 64;
    localparam int LEN_W  = 14;
    localparam int WORD_W = 12;
    localparam int MOD_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Byte j of word k carries seed + 8k + j (mod 256); only 8k mod 256 matters,
    // so the caller passes the low five bits of k. Bytes past bytes_valid read 0.
    function automatic logic [DATA_W-1:0] pattern_word(
        input logic [7:0] seed,
        input logic [4:0] k_lo,
        input logic [3:0] bytes_valid
    );
        logic [DATA_W-1:0] w;
        logic [7:0]        b;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            b = seed + {k_lo, 3'b000} + 8'(j);
            if (4'(j) < bytes_valid) begin
                w[63-8*j -: 8] = b;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/xge_pkt_tx_gen_if.sv
// MAC transmit packet bus: the generator is the master, the MAC TX FIFO the slave.
interface xge_pkt_tx_if;
    import xge_pkt_gen_pkg::*;

    logic [DATA_W-1:0] pkt_tx_data;
    logic              pkt_tx_val;
    logic              pkt_tx_sop;
    logic              pkt_tx_eop;
    logic [MOD_W-1:0]  pkt_tx_mod;
    logic              pkt_tx_full;

    modport master (
        output pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
        input  pkt_tx_full
    );

    modport slave (
        input  pkt_tx_data, pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_mod,
        output pkt_tx_full
    );

endinterface

// File: rtl/xge_pkt_tx_gen.sv
// Fixed-length frame generator with programmable count and inter-packet gap,
// driving the xge_mac pkt_tx bus under pkt_tx_full back-pressure.
//   state | meaning
//   IDLE  | waiting for cfg_start
//   SEND  | issuing words of the current frame
//   GAP   | counting cfg_ipg idle cycles between frames
//   DONE  | one-cycle done pulse, then back to IDLE
module xge_pkt_tx_gen
    import xge_pkt_gen_pkg::*;
#(
    parameter int LEN_MIN = 8,
    parameter int LEN_MAX = 9600,
    parameter int CNT_W   = 32
) (
    input  logic              clk_156m25,
    input  logic              reset_156m25,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [15:0]       cfg_num_pkts,
    input  logic [7:0]        cfg_ipg,
    xge_pkt_tx_if.master      pkt_tx,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tx_pkt_count
);

    state_t            state;
    logic [WORD_W-1:0] w_last;
    logic [3:0]        eop_bytes;
    logic [MOD_W-1:0]  eop_mod;
    logic [15:0]       num_r;
    logic [7:0]        ipg_r;
    logic [15:0]       frame_idx;
    logic [WORD_W-1:0] word_k;
    logic [7:0]        gap_cnt;
    logic              stop_pend;

    logic [LEN_W-1:0]  len_c;
    logic [LEN_W:0]    len_p7;
    logic [WORD_W-1:0] w_last_c;
    logic              last_word;
    logic              stop_now;
    logic              run_end;
    logic [3:0]        bytes_v;

    always_comb begin
        len_c = cfg_len;
        if (cfg_len < LEN_W'(LEN_MIN)) begin
            len_c = LEN_W'(LEN_MIN);
        end else if (cfg_len > LEN_W'(LEN_MAX)) begin
            len_c = LEN_W'(LEN_MAX);
        end
    end

    assign len_p7    = {1'b0, len_c} + (LEN_W+1)'(7);
    assign w_last_c  = len_p7[LEN_W:3] - WORD_W'(1);
    assign last_word = (word_k == w_last);
    assign stop_now  = stop_pend | cfg_stop;
    assign run_end   = stop_now || ((num_r != 16'd0) && ((frame_idx + 16'd1) == num_r));
    assign bytes_v   = last_word ? eop_bytes : 4'd8;

    always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
        if (reset_156m25) begin
            state              <= IDLE;
            w_last             <= '0;
            eop_bytes          <= '0;
            eop_mod            <= '0;
            num_r              <= '0;
            ipg_r              <= '0;
            frame_idx          <= '0;
            word_k             <= '0;
            gap_cnt            <= '0;
            stop_pend          <= 1'b0;
            busy               <= 1'b0;
            done               <= 1'b0;
            tx_pkt_count       <= '0;
            pkt_tx.pkt_tx_data <= '0;
            pkt_tx.pkt_tx_val  <= 1'b0;
            pkt_tx.pkt_tx_sop  <= 1'b0;
            pkt_tx.pkt_tx_eop  <= 1'b0;
            pkt_tx.pkt_tx_mod  <= '0;
        end else begin
            pkt_tx.pkt_tx_data <= '0;
            pkt_tx.pkt_tx_val  <= 1'b0;
            pkt_tx.pkt_tx_sop  <= 1'b0;
            pkt_tx.pkt_tx_eop  <= 1'b0;
            pkt_tx.pkt_tx_mod  <= '0;
            done               <= 1'b0;

            case (state)
                IDLE: begin
                    if (cfg_start) begin
                        w_last    <= w_last_c;
                        eop_mod   <= len_c[2:0];
                        eop_bytes <= (len_c[2:0] == 3'd0) ? 4'd8 : {1'b0, len_c[2:0]};
                        num_r     <= cfg_num_pkts;
                        ipg_r     <= cfg_ipg;
                        frame_idx <= '0;
                        word_k    <= '0;
                        stop_pend <= cfg_stop;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end

                SEND: begin
                    stop_pend <= stop_now;
                    if (!pkt_tx.pkt_tx_full) begin
                        pkt_tx.pkt_tx_val  <= 1'b1;
                        pkt_tx.pkt_tx_data <= pattern_word(frame_idx[7:0], word_k[4:0], bytes_v);
                        pkt_tx.pkt_tx_sop  <= (word_k == '0);
                        if (last_word) begin
                            pkt_tx.pkt_tx_eop <= 1'b1;
                            pkt_tx.pkt_tx_mod <= eop_mod;
                            tx_pkt_count      <= tx_pkt_count + CNT_W'(1);
                            frame_idx         <= frame_idx + 16'd1;
                            word_k            <= '0;
                            if (run_end) begin
                                state <= DONE;
                            end else if (ipg_r != 8'd0) begin
                                gap_cnt <= ipg_r;
                                state   <= GAP;
                            end
                        end else begin
                            word_k <= word_k + WORD_W'(1);
                        end
                    end
                end

                GAP: begin
                    stop_pend <= stop_now;
                    if (stop_now) begin
                        state <= DONE;
                    end else if (gap_cnt == 8'd1) begin
                        state <= SEND;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end

                DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    stop_pend <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xge_pkt_tx_gen.sv
// Directed and randomized bench for xge_pkt_tx_gen, checked against a
// byte-level frame model.
module tb_xge_pkt_tx_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_start = 1'b0;
    logic        cfg_stop = 1'b0;
    logic [13:0] cfg_len = '0;
    logic [15:0] cfg_num = '0;
    logic [7:0]  cfg_ipg = '0;
    logic        busy;
    logic        done;
    logic [31:0] tx_cnt;

    xge_pkt_tx_if bus();

    xge_pkt_tx_gen #(.LEN_MIN(8), .LEN_MAX(9600), .CNT_W(32)) dut (
        .clk_156m25   (clk),
        .reset_156m25 (rst),
        .cfg_start    (cfg_start),
        .cfg_stop     (cfg_stop),
        .cfg_len      (cfg_len),
        .cfg_num_pkts (cfg_num),
        .cfg_ipg      (cfg_ipg),
        .pkt_tx       (bus),
        .busy         (busy),
        .done         (done),
        .tx_pkt_count (tx_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int exp_count = 0;

    logic [63:0] m_data[$];
    logic [4:0]  m_ctl[$];
    int          m_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          bad_idle = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pkt_tx_val) begin
                m_data.push_back(bus.pkt_tx_data);
                m_ctl.push_back({bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod});
                m_cyc.push_back(cyc);
            end else if (bus.pkt_tx_data != '0 || bus.pkt_tx_sop || bus.pkt_tx_eop || bus.pkt_tx_mod != '0) begin
                bad_idle = bad_idle + 1;
            end
            if (done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int clamp_len(input int len);
        if (len < 8) return 8;
        if (len > 9600) return 9600;
        return len;
    endfunction

    // Byte idx of frame n is (n + idx) mod 256 up to the frame length, zero after.
    function automatic logic [63:0] ref_word(input int n, input int k, input int frame_len);
        logic [63:0] w;
        int idx;
        w = '0;
        for (int j = 0; j < 8; j++) begin
            idx = 8 * k + j;
            if (idx < frame_len) w[63-8*j -: 8] = 8'((n + idx) % 256);
        end
        return w;
    endfunction

    task automatic check_run(input string tag, input int len, input int nframes);
        int fl, nw, total, n, k;
        logic [4:0] ctl;
        fl = clamp_len(len);
        nw = (fl + 7) / 8;
        total = nframes * nw;
        chk({tag, "_nwords"}, 80'(m_data.size()), 80'(total));
        for (int i = 0; i < total && i < m_data.size(); i++) begin
            n = i / nw;
            k = i % nw;
            ctl = {k == 0, k == nw - 1, (k == nw - 1) ? 3'(fl % 8) : 3'd0};
            chk($sformatf("%s_word%0d", tag, i), {11'd0, m_data[i], m_ctl[i]}, {11'd0, ref_word(n, k, fl), ctl});
        end
        chk({tag, "_idle_clean"}, 80'(bad_idle), 80'd0);
    endtask

    task automatic start_run(input int len, input int num, input int ipg, input logic stop_too);
        m_data.delete();
        m_ctl.delete();
        m_cyc.delete();
        done_cnt = 0;
        bad_idle = 0;
        @(posedge clk); #1;
        cfg_len = 14'(len);
        cfg_num = 16'(num);
        cfg_ipg = 8'(ipg);
        cfg_start = 1'b1;
        cfg_stop = stop_too;
        @(posedge clk); #1;
        cfg_start = 1'b0;
        cfg_stop = 1'b0;
        chk("busy_rise", 80'(busy), 80'd1);
    endtask

    task automatic wait_words(input int n, input int budget);
        int i;
        i = 0;
        while (m_data.size() < n && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        chk("words_reached", 80'(m_data.size() >= n), 80'd1);
    endtask

    task automatic wait_done(input int budget, input bit rfull, input int nframes);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            @(posedge clk); #1;
            if (rfull) bus.pkt_tx_full = ($urandom_range(0, 3) == 0);
            i++;
        end
        bus.pkt_tx_full = 1'b0;
        chk("done_seen", 80'(done_cnt != 0), 80'd1);
        @(posedge clk); #1;
        chk("done_single", 80'(done_cnt), 80'd1);
        chk("busy_fall", 80'(busy), 80'd0);
        exp_count += nframes;
        chk("tx_pkt_count", 80'(tx_cnt), 80'(exp_count));
    endtask

    initial begin
        int len, num, ipg, nw;
        bus.pkt_tx_full = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", 80'(bus.pkt_tx_val), 80'd0);
        chk("rst_data", 80'(bus.pkt_tx_data), 80'd0);
        chk("rst_status", 80'({busy, done}), 80'd0);
        chk("rst_count", 80'(tx_cnt), 80'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Single 64-byte frame
        start_run(64, 1, 0, 1'b0);
        wait_done(200, 0, 1);
        check_run("t1", 64, 1);
        chk("t1_w0", 80'(m_data[0]), 80'h0001020304050607);
        chk("t1_w7", 80'(m_data[7]), 80'h38393A3B3C3D3E3F);
        chk("t1_done_lat", 80'(done_cyc - m_cyc[7]), 80'd1);

        // Two 65-byte frames with a 3-cycle gap
        start_run(65, 2, 3, 1'b0);
        wait_done(300, 0, 2);
        check_run("t2", 65, 2);
        chk("t2_eop", 80'(m_data[8]), 80'h4000000000000000);
        chk("t2_mod", 80'(m_ctl[8][2:0]), 80'd1);
        chk("t2_f1w0", 80'(m_data[9]), 80'h0102030405060708);
        chk("t2_gap", 80'(m_cyc[9] - m_cyc[8]), 80'd4);

        // Back-pressure held for 5 cycles mid-frame
        start_run(64, 1, 0, 1'b0);
        wait_words(3, 100);
        bus.pkt_tx_full = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.pkt_tx_full = 1'b0;
        wait_done(200, 0, 1);
        check_run("t3", 64, 1);
        chk("t3_span", 80'(m_cyc[7] - m_cyc[0]), 80'd12);

        // Continuous run stopped during frame 3
        start_run(64, 0, 0, 1'b0);
        wait_words(26, 200);
        cfg_stop = 1'b1;
        @(posedge clk); #1;
        cfg_stop = 1'b0;
        wait_done(200, 0, 4);
        check_run("t4", 64, 4);
        chk("t4_b2b_a", 80'(m_cyc[8] - m_cyc[7]), 80'd1);
        chk("t4_b2b_b", 80'(m_cyc[24] - m_cyc[23]), 80'd1);

        // Start and stop together: exactly one frame
        start_run(16, 5, 2, 1'b1);
        wait_done(200, 0, 1);
        check_run("t4b", 16, 1);

        // Length clamping
        start_run(3, 1, 0, 1'b0);
        wait_done(100, 0, 1);
        check_run("t5a", 3, 1);
        chk("t5a_ctl", 80'(m_ctl[0]), 80'({1'b1, 1'b1, 3'd0}));
        chk("t5a_data", 80'(m_data[0]), 80'h0001020304050607);
        start_run(10000, 1, 0, 1'b0);
        wait_done(3000, 0, 1);
        check_run("t5b", 10000, 1);

        // Reset in the middle of a frame
        start_run(64, 1, 0, 1'b0);
        wait_words(4, 100);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t6_val", 80'(bus.pkt_tx_val), 80'd0);
        chk("t6_data", 80'({bus.pkt_tx_data, bus.pkt_tx_sop, bus.pkt_tx_eop, bus.pkt_tx_mod}), 80'd0);
        chk("t6_status", 80'({busy, done}), 80'd0);
        chk("t6_count", 80'(tx_cnt), 80'd0);
        exp_count = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        start_run(64, 1, 0, 1'b0);
        wait_done(200, 0, 1);
        check_run("t6", 64, 1);

        // Randomized lengths, counts, gaps and back-pressure
        for (int r = 0; r < 8; r++) begin
            len = $urandom_range(1, 300);
            num = $urandom_range(1, 4);
            ipg = $urandom_range(0, 5);
            nw = (clamp_len(len) + 7) / 8;
            start_run(len, num, ipg, 1'b0);
            wait_done(num * (nw * 4 + ipg + 10) + 100, 1, num);
            check_run($sformatf("rnd%0d", r), len, num);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/xge_pkt_tx_gen.md
Name: xge_pkt_tx_gen

Overview:
Synthesizable packet generator that drives the MAC transmit packet interface (pkt_tx_*) of xge_mac in the clk_156m25 domain. It produces a programmed number of fixed-length frames with a deterministic byte pattern and a programmable inter-packet gap. It honours pkt_tx_full back-pressure. It is the stimulus stage directly upstream of the MAC TX FIFO, used in bring-up and loopback benches.

Parameters:
LEN_MIN, 8, minimum frame length in bytes; shorter cfg_len is clamped up to this.
LEN_MAX, 9600, maximum frame length in bytes; longer cfg_len is clamped down to this.
CNT_W, 32, width of the tx_pkt_count statistic.

Ports:
clk_156m25  in  1  core clock
reset_156m25  in  1  asynchronous reset, active-high
cfg_start  in  1  one-cycle pulse: begin a run (ignored while busy)
cfg_stop  in  1  level/pulse: finish the current frame, then end the run
cfg_len  in  14  frame length in bytes, sampled at start
cfg_num_pkts  in  16  frames per run, sampled at start; 0 = continuous until cfg_stop
cfg_ipg  in  8  idle cycles between eop and next sop, sampled at start
pkt_tx_full  in  1  MAC TX FIFO almost-full; no new word may be issued
pkt_tx_data  out  64  frame data; first byte in [63:56]
pkt_tx_val  out  1  word valid
pkt_tx_sop  out  1  first word of frame (only with val)
pkt_tx_eop  out  1  last word of frame (only with val)
pkt_tx_mod  out  3  valid bytes in eop word mod 8 (0 = all 8); 0 when not eop
busy  out  1  run in progress
done  out  1  one-cycle pulse at run end
tx_pkt_count  out  CNT_W  frames completed since reset (wraps)

Behaviour:
- Reset (async assert, sync deassert externally): every output is 0; FSM returns to IDLE; internal counters are cleared. Reset mid-frame truncates the frame with no eop, and val drops immediately.
- All pkt_tx_* outputs are registered. A word is presented in cycle t+1 only if pkt_tx_full was 0 at the edge ending cycle t and the FSM is in SEND. Otherwise val=0, and data, sop, eop and mod hold 0. The MAC FIFO full threshold must leave at least 2 words of headroom.
- Frame length: L = clamp(cfg_len, LEN_MIN, LEN_MAX). Words per frame W = ceil(L/8). Eop word mod = L[2:0].
- Data pattern: byte j of word k in frame n is (n[7:0] + 8k + j) mod 256, where n is the frame index within the run starting at 0. Bytes beyond L in the eop word are 0x00.
- FSM states and transitions:
  - IDLE: on cfg_start, latch the configuration, clear the frame index, set busy=1, go to SEND.
  - SEND: issue words k=0..W-1 subject to back-pressure. sop accompanies k=0 and eop accompanies k=W-1; when W=1, sop and eop are in the same word. After the eop word, tx_pkt_count increments.
    - If the run has ended (frames issued == cfg_num_pkts with cfg_num_pkts≠0, or a stop is pending), go to DONE.
    - Else if ipg=0, go to SEND: the next sop may be issued in the cycle immediately after eop, subject to full.
    - Else go to GAP.
  - GAP: val=0 for exactly cfg_ipg cycles, counted regardless of full, then go to SEND.
  - DONE: done=1 for one cycle, busy=0, go to IDLE.
- cfg_stop is latched as stop-pending whenever busy. It never truncates a frame. A stop during GAP goes to DONE at the next cycle.
- cfg_start while busy is ignored. cfg_start and cfg_stop in the same IDLE cycle start a run that ends after exactly 1 frame.
- The frame index and tx_pkt_count wrap silently.

Decomposition:
- Package xge_pkt_gen_pkg holds:
  - state enum {IDLE, SEND, GAP, DONE};
  - localparams for the data/length widths;
  - function pattern_word(seed, k, bytes_valid) returning the 64-bit word with byte masking.
- The FSM, word counter, gap counter and output registers are flat in one module; no sub-module is warranted.

Test Plan:
1. cfg_len=64, num=1, ipg=0, full=0 -> 8 words. Word0=0x0001020304050607 with sop. Word7=0x38393A3B3C3D3E3F with eop, mod=0. done pulses 1 cycle after eop; tx_pkt_count=1.
2. cfg_len=65, num=2, ipg=3 -> 9 words per frame. Frame0 eop word=0x4000000000000000, mod=1. Exactly 3 val=0 cycles follow, then frame1 word0=0x0102030405060708.
3. cfg_len=64, full toggling high for 5 cycles mid-frame -> exactly 5 cycles with no val; words resume in sequence with no duplicate or skipped k.
4. cfg_num_pkts=0, ipg=0; cfg_stop asserted mid-frame 3 -> frame 3 completes with eop, then done; tx_pkt_count=4; back-to-back sops occur between frames.
5. cfg_len=3 -> clamped to 8: single word with sop=eop=1, mod=0, data 0x0001020304050607. cfg_len=10000 -> 1200 words.
6. reset_156m25 asserted at word 4 of a 64-byte frame -> all outputs 0 asynchronously. A new cfg_start after release gives a frame starting at seed 0 with sop.
